// File: rtl/mod5_serial_sched_if.sv
// mod5_serial_sched_if: handshake and result bundle for the shared mod-5 engine.
//   W           word width in bits
//   req0_*      requester 0: valid/data in, ready out
//   req1_*      requester 1: valid/data in, ready out
//   res_*       result strobe, requester id, remainder, divisible flag
//   busy        scheduler not idle
//   res_parity  word parity, present only with MOD5_SCHED_PARITY_EN
// Modports: master = requester/consumer side, slave = scheduler side.
interface mod5_serial_sched_if #(
    parameter int unsigned W = 8
);
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         res_valid;
    logic         res_id;
    logic [2:0]   res_rem;
    logic         res_div;
    logic         busy;
`ifdef MOD5_SCHED_PARITY_EN
    logic         res_parity;
`endif

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, res_valid, res_id, res_rem, res_div, busy
`ifdef MOD5_SCHED_PARITY_EN
        , input res_parity
`endif
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, res_valid, res_id, res_rem, res_div, busy
`ifdef MOD5_SCHED_PARITY_EN
        , output res_parity
`endif
    );
endinterface

// File: rtl/mod5_serial_sched.sv
// mod5_serial_sched: round-robin scheduler sharing one MSB-first serial
// remainder-mod-5 engine between two requesters.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   mod5_serial_sched_if.slave (requests in, readies and results out)
// Optional feature macro: MOD5_SCHED_PARITY_EN adds res_parity (XOR of word bits).
module mod5_serial_sched #(
    parameter int unsigned W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mod5_serial_sched_if.slave      bus
);
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    logic [W-1:0]   sr;
    logic [CW-1:0]  cnt;
    logic [2:0]     rem;
    logic           id;
    logic           last_id;
    logic           res_valid;
    logic           res_id;
    logic [2:0]     res_rem;
    logic           res_div;
    logic           busy;
    logic           grant;
    logic           ready0;
    logic           ready1;
    logic           xfer;
    logic [2:0]     rem_n;
`ifdef MOD5_SCHED_PARITY_EN
    logic           par;
    logic           par_n;
    logic           res_parity;
`endif

    // One step of the MSB-first remainder FSM; illegal codes recover to 0.
    function automatic logic [2:0] rem_step(input logic [2:0] r, input logic b);
        case (r)
            3'd0:    rem_step = b ? 3'd1 : 3'd0;
            3'd1:    rem_step = b ? 3'd3 : 3'd2;
            3'd2:    rem_step = b ? 3'd0 : 3'd4;
            3'd3:    rem_step = b ? 3'd2 : 3'd1;
            3'd4:    rem_step = b ? 3'd4 : 3'd3;
            default: rem_step = 3'd0;
        endcase
    endfunction

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_id;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Readies are combinational and forced low while reset is held.
    assign ready0 = rst && (state == IDLE) && bus.req0_valid && (grant == 1'b0);
    assign ready1 = rst && (state == IDLE) && bus.req1_valid && (grant == 1'b1);
    assign xfer   = ready0 || ready1;
    assign rem_n  = rem_step(rem, sr[W-1]);
`ifdef MOD5_SCHED_PARITY_EN
    assign par_n  = par ^ sr[W-1];
`endif

    // Scheduler FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            rem       <= 3'd0;
            id        <= 1'b0;
            last_id   <= 1'b1;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_rem   <= 3'd0;
            res_div   <= 1'b0;
            busy      <= 1'b0;
`ifdef MOD5_SCHED_PARITY_EN
            par        <= 1'b0;
            res_parity <= 1'b0;
`endif
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sr      <= grant ? bus.req1_data : bus.req0_data;
                        rem     <= 3'd0;
                        cnt     <= CW'(W - 1);
                        id      <= grant;
                        last_id <= grant;
                        busy    <= 1'b1;
                        state   <= SHIFT;
`ifdef MOD5_SCHED_PARITY_EN
                        par     <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    rem <= rem_n;
                    sr  <= sr << 1;
                    cnt <= cnt - CW'(1);
`ifdef MOD5_SCHED_PARITY_EN
                    par <= par_n;
`endif
                    if (cnt == '0) begin
                        res_rem   <= rem_n;
                        res_div   <= (rem_n == 3'd0);
                        res_id    <= id;
                        res_valid <= 1'b1;
                        state     <= DONE;
`ifdef MOD5_SCHED_PARITY_EN
                        res_parity <= par_n;
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = res_valid;
    assign bus.res_id     = res_id;
    assign bus.res_rem    = res_rem;
    assign bus.res_div    = res_div;
    assign bus.busy       = busy;
`ifdef MOD5_SCHED_PARITY_EN
    assign bus.res_parity = res_parity;
`endif
endmodule

// File: tb/tb_mod5_serial_sched.sv
// tb_mod5_serial_sched: directed self-checking bench for mod5_serial_sched.
// Parity checks are included when MOD5_SCHED_PARITY_EN is defined.
module tb_mod5_serial_sched;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   both_ready = 0;

    always #5 clk = ~clk;

    mod5_serial_sched_if #(.W(W)) bus ();

    mod5_serial_sched #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Readies must never be high together.
    always @(negedge clk) begin
        if (bus.req0_ready && bus.req1_ready) both_ready++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for res_valid, returning edges seen (start counts the transfer edge).
    task automatic wait_res(input int start, output int edges);
        edges = start;
        while (bus.res_valid !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
    endtask

    // Issue one word on requester r and check handshake, latency and result.
    task automatic issue(input string tag, input logic r, input logic [W-1:0] d,
                         input logic [2:0] exp_rem, input logic exp_par);
        int edges;
        if (r) begin
            bus.req1_valid = 1'b1; bus.req1_data = d;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_data = d;
        end
        #1;
        check({tag, " ready"}, {31'd0, r ? bus.req1_ready : bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
        wait_res(1, edges);
        check({tag, " latency"}, 32'(edges), 32'(W + 1));
        check({tag, " rem"}, {29'd0, bus.res_rem}, {29'd0, exp_rem});
        check({tag, " div"}, {31'd0, bus.res_div}, {31'd0, exp_rem == 3'd0});
        check({tag, " id"}, {31'd0, bus.res_id}, {31'd0, r});
`ifdef MOD5_SCHED_PARITY_EN
        check({tag, " parity"}, {31'd0, bus.res_parity}, {31'd0, exp_par});
`else
        if (exp_par) begin end
`endif
        step();
        check({tag, " strobe end"}, {31'd0, bus.res_valid}, 32'd0);
        check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " rem hold"}, {29'd0, bus.res_rem}, {29'd0, exp_rem});
    endtask

    int res_cyc[4];
    int res_id_q[4];
    int res_rem_q[4];
    int n_res;
    int edges;

    initial begin
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'd25;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;

        // Reset with a pending valid: everything quiet.
        #3;
        check("rst ready0", {31'd0, bus.req0_ready}, 32'd0);
        check("rst ready1", {31'd0, bus.req1_ready}, 32'd0);
        check("rst res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst res_id", {31'd0, bus.res_id}, 32'd0);
        check("rst res_rem", {29'd0, bus.res_rem}, 32'd0);
        check("rst res_div", {31'd0, bus.res_div}, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        step(); step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle busy", {31'd0, bus.busy}, 32'd0);
            check("idle res_valid", {31'd0, bus.res_valid}, 32'd0);
        end

        // Single words.
        issue("r0 25", 1'b0, 8'd25, 3'd0, 1'b1);
        issue("r1 7", 1'b1, 8'd7, 3'd2, 1'b1);
        issue("r1 255", 1'b1, 8'd255, 3'd0, 1'b0);
        issue("r1 0", 1'b1, 8'd0, 3'd0, 1'b0);
        issue("r1 254", 1'b1, 8'd254, 3'd4, 1'b1);

        // Both requesters valid continuously: round-robin alternation.
        bus.req0_valid = 1'b1; bus.req0_data = 8'd10;
        bus.req1_valid = 1'b1; bus.req1_data = 8'd11;
        n_res = 0;
        for (int i = 0; i < 60 && n_res < 4; i++) begin
            step();
            if (bus.res_valid === 1'b1) begin
                res_cyc[n_res]   = i;
                res_id_q[n_res]  = int'(bus.res_id);
                res_rem_q[n_res] = int'(bus.res_rem);
                n_res++;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("rr count", 32'(n_res), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("rr id", 32'(res_id_q[k]), 32'(k % 2));
            check("rr rem", 32'(res_rem_q[k]), 32'(k % 2));
        end
        for (int k = 1; k < 4; k++) begin
            check("rr spacing", 32'(res_cyc[k] - res_cyc[k-1]), 32'd10);
        end
        step(); step();

        // Reset in the third SHIFT cycle, with req1 waiting.
        bus.req0_valid = 1'b1; bus.req0_data = 8'd7;
        step();
        bus.req0_valid = 1'b0;
        step(); step();
        bus.req1_valid = 1'b1; bus.req1_data = 8'd254;
        rst = 1'b0;
        #1;
        check("mid rst busy", {31'd0, bus.busy}, 32'd0);
        check("mid rst res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("mid rst ready1", {31'd0, bus.req1_ready}, 32'd0);
        step(); step();
        check("mid rst hold res_valid", {31'd0, bus.res_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("post rst ready1", {31'd0, bus.req1_ready}, 32'd1);
        check("post rst ready0", {31'd0, bus.req0_ready}, 32'd0);
        step();
        bus.req1_valid = 1'b0;
        wait_res(1, edges);
        check("post rst latency", 32'(edges), 32'(W + 1));
        check("post rst rem", {29'd0, bus.res_rem}, 32'd4);
        check("post rst id", {31'd0, bus.res_id}, 32'd1);
        step();

        // Tie after reset: last_id is back to 1, so req0 wins.
        bus.req0_valid = 1'b1; bus.req0_data = 8'd3;
        bus.req1_valid = 1'b1; bus.req1_data = 8'd4;
        #1;
        check("tie ready0", {31'd0, bus.req0_ready}, 32'd1);
        check("tie ready1", {31'd0, bus.req1_ready}, 32'd0);
        step();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_res(1, edges);
        check("tie rem", {29'd0, bus.res_rem}, 32'd3);
        check("tie id", {31'd0, bus.res_id}, 32'd0);
        step();

`ifdef MOD5_SCHED_PARITY_EN
        issue("par b5", 1'b0, 8'hB5, 3'd1, 1'b1);
        issue("par 03", 1'b0, 8'h03, 3'd3, 1'b0);
`endif

        check("never both ready", 32'(both_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
